// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, control FSM states
// and the datapath select encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_ILLEGAL
  } ctrl_state_t;

  typedef enum logic [1:0] {
    SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10
  } pc_src_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_src_t    pc_src;
    logic       pc_en;
    logic       illegal;
  } ctrl_out_t;

  // An instruction completes on the edge leaving its final state.
  function automatic logic retires(input ctrl_state_t s, input logic mem_ready);
    return (s inside {S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP}) ||
           (s == S_MEMWR && mem_ready);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and the datapath.
interface mips_multicycle_ctrl_if #(parameter int unsigned CNT_W = 32);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_write;
  logic             iord;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic             pc_en;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal, retired
  );
endinterface

// File: rtl/ctrl_out_decode.sv
// Moore decode of controller state into datapath controls; only FETCH looks
// at mem_ready and only BRANCH looks at zero.
module ctrl_out_decode
  import mips_pkg::*;
(
  input  ctrl_state_t state,
  input  logic        mem_ready,
  input  logic        zero,
  output ctrl_out_t   ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALUOP_ADD;
        ctrl_c.pc_src    = PCSRC_ALU;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_en     = mem_ready;
      end
      S_DECODE: ctrl_c.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.mem_write = 1'b1;
        ctrl_c.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
      end
      S_ADDIWB: ctrl_c.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_op    = ALUOP_SUB;
        ctrl_c.pc_src    = PCSRC_ALUOUT;
        ctrl_c.pc_en     = zero;
      end
      S_JUMP: begin
        ctrl_c.pc_src = PCSRC_JUMP;
        ctrl_c.pc_en  = 1'b1;
      end
      S_ILLEGAL: ctrl_c.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core with retired-instruction counter.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  mips_multicycle_ctrl_if.master bus
);

  ctrl_state_t      state;
  ctrl_state_t      dec_state;
  ctrl_out_t        ctrl_c;
  logic             is_lw;
  logic [CNT_W-1:0] retired_q;

  // The lw/sw split is latched in DECODE so opcode is never looked at later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      is_lw     <= 1'b0;
      retired_q <= '0;
    end else begin
      if (retires(state, bus.mem_ready)) retired_q <= retired_q + CNT_W'(1);
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          is_lw <= (bus.opcode == OP_LW);
          case (bus.opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            default:      state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR: state <= is_lw ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ADDIEX: state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP, S_ILLEGAL: state <= S_FETCH;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Holding reset forces the quiet IDLE decode even before the reset edge lands.
  assign dec_state = rst_n ? state : S_IDLE;

  ctrl_out_decode u_decode (
    .state     (dec_state),
    .mem_ready (bus.mem_ready),
    .zero      (bus.zero),
    .ctrl_c    (ctrl_c)
  );

  assign bus.mem_req    = ctrl_c.mem_req;
  assign bus.mem_write  = ctrl_c.mem_write;
  assign bus.iord       = ctrl_c.iord;
  assign bus.ir_write   = ctrl_c.ir_write;
  assign bus.reg_dst    = ctrl_c.reg_dst;
  assign bus.mem_to_reg = ctrl_c.mem_to_reg;
  assign bus.reg_write  = ctrl_c.reg_write;
  assign bus.alu_src_a  = ctrl_c.alu_src_a;
  assign bus.alu_src_b  = ctrl_c.alu_src_b;
  assign bus.alu_op     = ctrl_c.alu_op;
  assign bus.pc_src     = ctrl_c.pc_src;
  assign bus.pc_en      = ctrl_c.pc_en;
  assign bus.illegal    = ctrl_c.illegal;
  assign bus.retired    = rst_n ? retired_q : '0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench: an instruction-level model emits expected
// per-cycle control words, a negedge monitor compares them against the DUT.
module tb_mips_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  typedef struct packed {
    logic [15:0] ov;
    logic [3:0]  rv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] mon_o;
  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  logic [3:0]  model_cnt;

  // {req,wr,iord,irw,rdst,m2r,rw,srca,srcb,aluop,pcsrc,pcen,ill}
  function automatic logic [15:0] pack(input logic req, wr, ad, irw, rd, m2r, rw, sa,
                                       input logic [1:0] sb, op, ps,
                                       input logic pe, il);
    return {req, wr, ad, irw, rd, m2r, rw, sa, sb, op, ps, pe, il};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == RT || op == LW || op == SW || op == BEQ || op == ADDI || op == JMP;
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] tbl [6];
    logic [5:0] o;
    int k;
    tbl = '{RT, LW, SW, BEQ, ADDI, JMP};
    k = int'($urandom_range(0, 7));
    if (k < 6) return tbl[k];
    do o = rop(); while (is_legal(o));
    return o;
  endfunction

  // One clock of stimulus plus the response the model requires in that clock.
  task automatic step(input logic rn, mr, z, input logic [5:0] op, input logic [15:0] e);
    @(posedge clk);
    #1;
    rst_n         = rn;
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.opcode    = op;
    exp_q.push_back({e, rn ? model_cnt : 4'd0});
  endtask

  task automatic do_reset();
    step(1'b0, rb(), rb(), rop(), 16'h0);
    model_cnt = 4'd0;
    step(1'b1, rb(), rb(), rop(), 16'h0);
  endtask

  task automatic fetch(input int w);
    repeat (w) step(1'b1, 1'b0, rb(), rop(), pack(1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0));
    step(1'b1, 1'b1, rb(), rop(), pack(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0));
  endtask

  task automatic decode(input logic [5:0] op);
    step(1'b1, rb(), rb(), op, pack(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0));
  endtask

  task automatic instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    fetch(fw);
    decode(op);
    case (op)
      LW: begin
        step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
        repeat (mw) step(1'b1, 1'b0, rb(), rop(), pack(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
        step(1'b1, 1'b1, rb(), rop(), pack(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
        step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0));
        model_cnt = model_cnt + 4'd1;
      end
      SW: begin
        step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
        repeat (mw) step(1'b1, 1'b0, rb(), rop(), pack(1,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
        step(1'b1, 1'b1, rb(), rop(), pack(1,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
        model_cnt = model_cnt + 4'd1;
      end
      RT: begin
        step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0));
        step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0));
        model_cnt = model_cnt + 4'd1;
      end
      ADDI: begin
        step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
        step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0));
        model_cnt = model_cnt + 4'd1;
      end
      BEQ: begin
        step(1'b1, rb(), z, rop(), pack(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,z,0));
        model_cnt = model_cnt + 4'd1;
      end
      JMP: begin
        step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0));
        model_cnt = model_cnt + 4'd1;
      end
      default: step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1));
    endcase
  endtask

  // Monitor: the DUT presents a control word every cycle.
  always @(negedge clk) begin
    cyc_n++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_o = {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.reg_dst,
               bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
               bus.alu_op, bus.pc_src, bus.pc_en, bus.illegal};
      checks++;
      if (mon_o !== mon_e.ov) begin
        errors++;
        $display("FAIL ctrl_word cycle %0d: got %b expected %b", cyc_n, mon_o, mon_e.ov);
      end
      checks++;
      if (bus.retired !== mon_e.rv) begin
        errors++;
        $display("FAIL retired cycle %0d: got %0d expected %0d", cyc_n, bus.retired, mon_e.rv);
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.opcode    = 6'd0;
    model_cnt     = 4'd0;
    do_reset();

    // Reset while lw stalls in MEMRD
    fetch(0);
    decode(LW);
    step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
    repeat (3) step(1'b1, 1'b0, rb(), rop(), pack(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
    do_reset();

    instr(RT, 0, 0, 1'b0);
    instr(LW, 2, 2, 1'b0);
    instr(BEQ, 0, 0, 1'b1);
    instr(BEQ, 0, 0, 1'b0);
    instr(SW, 0, 0, 1'b0);
    instr(JMP, 0, 0, 1'b0);
    instr(6'b111111, 0, 0, 1'b0);
    instr(ADDI, 1, 0, 1'b0);

    // Reset while FETCH is stalled
    repeat (2) step(1'b1, 1'b0, rb(), rop(), pack(1,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0));
    do_reset();

    // Bring the counter to all ones, then illegal, then wrap
    while (model_cnt != 4'hF) instr(JMP, 0, 0, 1'b0);
    instr(6'b111111, 0, 0, 1'b0);
    instr(RT, 0, 0, 1'b0);

    for (int i = 0; i < 150; i++)
      instr(rand_op(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb());

    // Reset while sw stalls in MEMWR
    fetch(0);
    decode(SW);
    step(1'b1, rb(), rb(), rop(), pack(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0));
    repeat (2) step(1'b1, 1'b0, rb(), rop(), pack(1,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0));
    do_reset();
    instr(SW, 1, 1, 1'b0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
